ws_tile_sequencer: RTL and testbench
====================================

Name: ws_tile_sequencer

Overview:
- Synthesizable sequencer that drives the left (activations) and top (weights) edges of a weight-stationary N x N systolic array.
- Per tile: loads N weight rows, streams a programmable number of activation vectors with optional per-row skew, then drains the array and pulses done.
- Valid/ready streams on both inputs, plus utilisation and stall counters for on-chip profiling.
- Sits between the tile DMA/buffers and the array instance.

Parameters:
- D_W, 8, element width in bits.
- N, 8, array dimension: lanes per vector and weight rows per tile.
- MAX_VEC, 1024, maximum activation vectors per tile; CNT_W = $clog2(MAX_VEC+1).
- SKEW_EN, 1, 1 = lane r delayed r cycles on m0; 0 = all lanes aligned.
- PC_W, 32, profiling counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  begin a tile; sampled only in IDLE.
- num_vec  in  CNT_W  activation vectors in this tile; latched on accepted start.
- w_valid  in  1  weight row valid.
- w_ready  out  1  weight row accepted this cycle when w_valid & w_ready.
- w_data  in  N*D_W  weight row; lane c at bits [c*D_W +: D_W]; rows arrive row N-1 first.
- a_valid  in  1  activation vector valid.
- a_ready  out  1  activation accept.
- a_data  in  N*D_W  activation vector; lane r at [r*D_W +: D_W].
- load_weight  out  1  array weight-shift enable.
- m1  out  N*D_W  top-edge weight data.
- m0  out  N*D_W  left-edge activation data, skewed.
- phase  out  2  0 IDLE, 1 LOAD, 2 COMPUTE, 3 DRAIN.
- busy  out  1  phase != IDLE.
- done  out  1  one-cycle pulse at tile end.
- active_cycles  out  PC_W  COMPUTE-phase accepted vectors with any nonzero lane.
- stall_cycles  out  PC_W  COMPUTE-phase cycles with a_valid=0.

Behaviour:
- Reset (rst=0 at posedge): phase=IDLE, all outputs 0, skew registers 0, counters 0. Reset mid-tile aborts the tile with no done pulse.
- IDLE:
  - w_ready=0, a_ready=0.
  - start=1 → LOAD on the next cycle; num_vec latched; both counters cleared to 0.
  - start while busy is ignored.
- LOAD:
  - w_ready=1; row counter counts 0..N-1.
  - Each accepted row appears on m1 with load_weight=1 in the following cycle (1-cycle registered latency).
  - Cycles with no accepted row: load_weight=0 and m1 holds its last value, so the array does not shift.
  - After the Nth accepted row: next state is COMPUTE, or DRAIN if the latched num_vec=0.
  - Following the Nth row's load_weight=1 cycle, load_weight=0 and m1=0.
- COMPUTE:
  - a_ready=1 and vec counter counts 0..num_vec-1.
  - A vector accepted at cycle t drives lane r on m0 at t+1+r when SKEW_EN=1, or t+1 for all lanes when SKEW_EN=0.
  - A cycle with a_valid=0 injects a zero vector into the skew pipe (bubble) and increments stall_cycles.
  - An accepted vector with any nonzero lane increments active_cycles.
  - After the last vector is accepted → DRAIN; a_ready drops the same cycle the state changes.
- DRAIN:
  - Zeros are fed into the skew pipe for 2N-1 cycles (skew flush N-1 plus propagation N); a_ready=0.
  - In the last DRAIN cycle done=1 and next state is IDLE.
  - start in that same cycle is ignored; a new tile needs start in IDLE.
- Counters saturate at 2^PC_W-1 and hold their values in IDLE until the next start.
- Skew pipe: lane r is an r-deep shift register (lane 0 is register-only). It advances every cycle in COMPUTE and DRAIN, and is zeroed in IDLE and LOAD.
- Weights are never modified; no arithmetic other than counters.

Decomposition:
- Package ws_seq_pkg:
  - phase_e enum (IDLE, LOAD, COMPUTE, DRAIN).
  - Lane slice helper function.
  - Localparam DRAIN_CYC = 2*N-1.
- Sub-module ws_skew_line: per-lane delay line with parameters D_W and DEPTH (DEPTH=0 passes the register stage only). It is generated N times with DEPTH=r*SKEW_EN.

Test Plan:
- Basic tile, N=4, SKEW_EN=1:
  - Stimulus: 4 weight rows 0x01..0x04 back-to-back, then num_vec=3 vectors {1,2,3,4}.
  - Required: load_weight high exactly 4 cycles, m1 row order preserved.
  - Required: lane 3 of vector 0 appears on m0 4 cycles after acceptance.
  - Required: done exactly 2N-1=7 cycles after the last vector's phase exit; active_cycles=3.
- Weight gaps: deassert w_valid for 2 cycles between rows 1 and 2 → load_weight=0 on those cycles, m1 held, still exactly 4 shift cycles total.
- Activation bubbles: with num_vec=5, a_valid toggles 1,0,1,0,... → stall_cycles equals the number of a_valid=0 COMPUTE cycles; zero lanes appear on m0 at the bubble slots.
- num_vec=0: after load, phase goes directly to DRAIN; m0 all zero; done fires; both counters are 0.
- All-zero vector among 4 vectors → active_cycles=3.
- Reset mid-COMPUTE: rst=0 for 1 cycle → next cycle phase=IDLE, m0=0, load_weight=0, busy=0, no done pulse; a following start runs a full tile correctly.

Source files
------------

// File: rtl/ws_seq_pkg.sv
// Shared types and helpers for the weight-stationary tile sequencer.
package ws_seq_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_LOAD    = 2'd1,
    PH_COMPUTE = 2'd2,
    PH_DRAIN   = 2'd3
  } phase_e;

  localparam int N_DEF     = 8;
  localparam int DRAIN_CYC = 2 * N_DEF - 1;

  // Drain length for an n x n array: skew flush (n-1) plus propagation (n).
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

  // Bit offset of lane `lane` inside a packed N*d_w vector.
  function automatic int lane_lsb(input int lane, input int d_w);
    return lane * d_w;
  endfunction

endpackage

// File: rtl/ws_skew_line.sv
// One lane of the left-edge skew pipe: a register stage followed by DEPTH delay stages.
module ws_skew_line #(
  parameter int D_W   = 8,
  parameter int DEPTH = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clr,
  input  logic [D_W-1:0] i_d,
  output logic [D_W-1:0] o_q
);

  logic [D_W-1:0] r_stage [0:DEPTH];

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      for (int i = 0; i <= DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i <= DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH];

endmodule

// File: rtl/ws_tile_sequencer.sv
// Drives weight (top) and skewed activation (left) edges of an N x N weight-stationary array,
// one tile at a time: LOAD N rows, COMPUTE num_vec vectors, DRAIN 2N-1 cycles, pulse done.
module ws_tile_sequencer
  import ws_seq_pkg::*;
#(
  parameter  int D_W     = 8,
  parameter  int N       = 8,
  parameter  int MAX_VEC = 1024,
  parameter  int SKEW_EN = 1,
  parameter  int PC_W    = 32,
  localparam int CNT_W   = $clog2(MAX_VEC + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vec,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [N*D_W-1:0]   w_data,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [N*D_W-1:0]   a_data,
  output logic               load_weight,
  output logic [N*D_W-1:0]   m1,
  output logic [N*D_W-1:0]   m0,
  output logic [1:0]         phase,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    active_cycles,
  output logic [PC_W-1:0]    stall_cycles
);

  localparam logic [1:0] S_IDLE    = PH_IDLE;
  localparam logic [1:0] S_LOAD    = PH_LOAD;
  localparam logic [1:0] S_COMPUTE = PH_COMPUTE;
  localparam logic [1:0] S_DRAIN   = PH_DRAIN;

  localparam int DRAIN_LEN = drain_cycles(N);
  localparam int ROW_W     = $clog2(N + 1);
  localparam int DR_W      = $clog2(DRAIN_LEN + 1);

  logic [1:0]       r_state;
  logic [ROW_W-1:0] r_row_cnt;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_num_vec;
  logic [DR_W-1:0]  r_drain_cnt;
  logic [N*D_W-1:0] r_m1;
  logic             r_load_weight;
  logic [PC_W-1:0]  r_active;
  logic [PC_W-1:0]  r_stall;

  logic             w_row_acc;
  logic             w_vec_acc;
  logic             w_last_row;
  logic             w_last_vec;
  logic             w_last_drain;
  logic             w_pipe_clr;
  logic [N*D_W-1:0] w_inject;

  assign w_ready      = (r_state == S_LOAD);
  assign a_ready      = (r_state == S_COMPUTE);
  assign w_row_acc    = w_valid & w_ready;
  assign w_vec_acc    = a_valid & a_ready;
  assign w_last_row   = (r_row_cnt == ROW_W'(N - 1));
  assign w_last_vec   = ((r_vec_cnt + CNT_W'(1)) == r_num_vec);
  assign w_last_drain = (r_drain_cnt == DR_W'(DRAIN_LEN - 1));
  assign w_pipe_clr   = (r_state == S_IDLE) || (r_state == S_LOAD);
  // Bubbles and drain cycles push zeros so the array sees no stale activations.
  assign w_inject     = w_vec_acc ? a_data : '0;

  assign phase         = r_state;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DRAIN) && w_last_drain;
  assign load_weight   = r_load_weight;
  assign m1            = r_m1;
  assign active_cycles = r_active;
  assign stall_cycles  = r_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_row_cnt   <= '0;
      r_vec_cnt   <= '0;
      r_num_vec   <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_LOAD;
            r_num_vec <= num_vec;
            r_row_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (w_row_acc) begin
            r_row_cnt <= r_row_cnt + 1'b1;
            if (w_last_row) begin
              r_state     <= (r_num_vec == '0) ? S_DRAIN : S_COMPUTE;
              r_vec_cnt   <= '0;
              r_drain_cnt <= '0;
            end
          end
        end
        S_COMPUTE: begin
          if (w_vec_acc) begin
            r_vec_cnt <= r_vec_cnt + 1'b1;
            if (w_last_vec) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 1'b1;
          if (w_last_drain) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // m1 holds through LOAD gaps so the array never shifts a stale row; zero elsewhere.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m1          <= '0;
      r_load_weight <= 1'b0;
    end else if (w_row_acc) begin
      r_m1          <= w_data;
      r_load_weight <= 1'b1;
    end else begin
      r_load_weight <= 1'b0;
      if (r_state != S_LOAD) r_m1 <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_active <= '0;
      r_stall  <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_active <= '0;
      r_stall  <= '0;
    end else if (r_state == S_COMPUTE) begin
      if (w_vec_acc && (|a_data) && (r_active != '1)) r_active <= r_active + 1'b1;
      if (!a_valid && (r_stall != '1))                r_stall  <= r_stall + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    ws_skew_line #(
      .D_W   (D_W),
      .DEPTH (gi * SKEW_EN)
    ) u_skew (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_pipe_clr),
      .i_d   (w_inject[lane_lsb(gi, D_W) +: D_W]),
      .o_q   (m0[lane_lsb(gi, D_W) +: D_W])
    );
  end

endmodule

// File: tb/tb_ws_tile_sequencer.sv
// Self-checking bench: directed plus randomized tiles against a cycle-level stream model.
module tb_ws_tile_sequencer;

  localparam int D_W       = 8;
  localparam int N         = 4;
  localparam int MAX_VEC   = 32;
  localparam int SKEW_EN   = 1;
  localparam int PC_W      = 4;
  localparam int CNT_W     = $clog2(MAX_VEC + 1);
  localparam int W         = N * D_W;
  localparam int DRAIN_LEN = 2 * N - 1;
  localparam int SAT       = (1 << PC_W) - 1;
  localparam int TILE_LIM  = 3000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             w_valid = 1'b0;
  logic             w_ready;
  logic [W-1:0]     w_data = '0;
  logic             a_valid = 1'b0;
  logic             a_ready;
  logic [W-1:0]     a_data = '0;
  logic             load_weight;
  logic [W-1:0]     m1;
  logic [W-1:0]     m0;
  logic [1:0]       phase;
  logic             busy;
  logic             done;
  logic [PC_W-1:0]  active_cycles;
  logic [PC_W-1:0]  stall_cycles;

  ws_tile_sequencer #(
    .D_W(D_W), .N(N), .MAX_VEC(MAX_VEC), .SKEW_EN(SKEW_EN), .PC_W(PC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .load_weight(load_weight), .m1(m1), .m0(m0), .phase(phase),
    .busy(busy), .done(done), .active_cycles(active_cycles), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: phases from the tile rules, left edge as "stream delayed by lane index".
  int           m_ph = 0, m_rows = 0, m_vecs = 0, m_nv = 0, m_drain = 0;
  int           m_act = 0, m_stall = 0;
  bit           m_lw = 1'b0;
  logic [W-1:0] m_m1 = '0;
  logic [W-1:0] m_stream [N];

  initial begin
    for (int k = 0; k < N; k++) m_stream[k] = '0;
    forever begin
      logic [W-1:0] inj;
      bit           zero_pipe;
      @(posedge clk);
      cyc++;
      inj = '0;
      if (!rst) begin
        m_ph = 0; m_lw = 1'b0; m_m1 = '0; m_act = 0; m_stall = 0;
        for (int k = 0; k < N; k++) m_stream[k] = '0;
      end else begin
        zero_pipe = (m_ph == 0) || (m_ph == 1);
        case (m_ph)
          0: begin
            m_lw = 1'b0; m_m1 = '0;
            if (start) begin
              m_ph = 1; m_nv = int'(num_vec); m_rows = 0; m_act = 0; m_stall = 0;
            end
          end
          1: begin
            if (w_valid) begin
              m_m1 = w_data; m_lw = 1'b1; m_rows++;
              if (m_rows == N) begin
                m_ph = (m_nv == 0) ? 3 : 2; m_vecs = 0; m_drain = 0;
              end
            end else m_lw = 1'b0;
          end
          2: begin
            m_lw = 1'b0; m_m1 = '0;
            if (a_valid) begin
              inj = a_data;
              if (a_data != '0 && m_act < SAT) m_act++;
              m_vecs++;
              if (m_vecs == m_nv) m_ph = 3;
            end else if (m_stall < SAT) m_stall++;
          end
          default: begin
            m_lw = 1'b0; m_m1 = '0;
            m_drain++;
            if (m_drain == DRAIN_LEN) m_ph = 0;
          end
        endcase
        for (int k = N - 1; k > 0; k--) m_stream[k] = m_stream[k-1];
        m_stream[0] = inj;
        if (zero_pipe) for (int k = 0; k < N; k++) m_stream[k] = '0;
      end
    end
  end

  // Per-tile observations used by the hand-computed checks.
  int           lw_cnt = 0, done_cnt = 0, done_cyc = -1;
  logic [W-1:0] m0_hist [64];
  logic [W-1:0] m1_q [$];

  initial begin
    forever begin
      logic [W-1:0] e_m0;
      @(negedge clk);
      for (int r = 0; r < N; r++) e_m0[r*D_W +: D_W] = m_stream[r][r*D_W +: D_W];
      chk("phase",   64'(phase),         64'(m_ph));
      chk("busy",    64'(busy),          64'(m_ph != 0));
      chk("done",    64'(done),          64'(m_ph == 3 && m_drain == DRAIN_LEN - 1));
      chk("w_ready", 64'(w_ready),       64'(m_ph == 1));
      chk("a_ready", 64'(a_ready),       64'(m_ph == 2));
      chk("load_w",  64'(load_weight),   64'(m_lw));
      chk("m1",      64'(m1),            64'(m_m1));
      chk("m0",      64'(m0),            64'(e_m0));
      chk("active",  64'(active_cycles), 64'(m_act));
      chk("stall",   64'(stall_cycles),  64'(m_stall));
      lw_cnt += int'(load_weight);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (load_weight) m1_q.push_back(m1);
      m0_hist[cyc % 64] = m0;
    end
  end

  int first_acc, last_acc, last_row_cyc;

  // amode: 0 always valid, 1 toggle 1,0,1..., 2 random. abort_at>=0 resets after that many COMPUTE cycles.
  task automatic run_tile(input int nv, input int wgap_row, input int amode, input int zidx,
                          input bit fixed, input int abort_at);
    int row = 0, vec = 0, guard = 0, gap = 0, ccyc = 0;
    bit tog = 1'b1;
    lw_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_acc = -1; last_acc = -1; last_row_cyc = -1;
    m1_q.delete();
    start = 1'b1; num_vec = CNT_W'(nv);
    @(posedge clk); #1;
    start = 1'b0;
    while (busy === 1'b1 && guard < TILE_LIM) begin
      guard++;
      w_valid = 1'b0; a_valid = 1'b0; w_data = '0; a_data = '0;
      if (w_ready) begin
        if (row == wgap_row && gap < 2) gap++;
        else begin
          w_valid = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
          for (int c = 0; c < N; c++) w_data[c*D_W +: D_W] = fixed ? D_W'(row + 1) : D_W'($urandom);
          if (w_valid) begin row++; last_row_cyc = cyc; end
        end
      end else if (a_ready) begin
        case (amode)
          0:       a_valid = 1'b1;
          1:       begin a_valid = tog; tog = !tog; end
          default: a_valid = ($urandom_range(0, 2) != 0);
        endcase
        if (a_valid) begin
          for (int r = 0; r < N; r++) a_data[r*D_W +: D_W] = fixed ? D_W'(r + 1) : D_W'($urandom_range(0, 3));
          if (vec == zidx) a_data = '0;
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          vec++;
        end
        ccyc++;
        if (abort_at >= 0 && ccyc == abort_at) begin
          rst = 1'b0;
          @(posedge clk); #1;
          rst = 1'b1; a_valid = 1'b0; a_data = '0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    w_valid = 1'b0; a_valid = 1'b0; w_data = '0; a_data = '0;
    n_chk++;
    if (guard >= TILE_LIM) begin
      n_fail++;
      $display("FAIL tile_timeout: busy still %0b after %0d cycles, limit %0d", busy, guard, TILE_LIM);
    end
  endtask

  task automatic basic_literals();
    logic [W-1:0] exp_rows [4];
    logic [W-1:0] v;
    exp_rows[0] = 32'h01010101; exp_rows[1] = 32'h02020202;
    exp_rows[2] = 32'h03030303; exp_rows[3] = 32'h04040404;
    chk("lit_lw_count", 64'(lw_cnt), 64'd4);
    chk("lit_m1_rows",  64'(m1_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < m1_q.size(); k++) chk("lit_m1_order", 64'(m1_q[k]), 64'(exp_rows[k]));
    v = m0_hist[(first_acc + 4) % 64];
    chk("lit_lane3_v0", 64'(v[31:24]), 64'h04);
    v = m0_hist[(first_acc + 3) % 64];
    chk("lit_lane3_early", 64'(v[31:24]), 64'h00);
    chk("lit_done_lat", 64'(done_cyc - last_acc), 64'd7);
    chk("lit_done_cnt", 64'(done_cnt), 64'd1);
    chk("lit_active",   64'(active_cycles), 64'd3);
    chk("lit_stall",    64'(stall_cycles), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    int nv;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("lit_reset_phase", 64'(phase), 64'd0);
    chk("lit_reset_m0",    64'(m0), 64'd0);
    chk("lit_reset_act",   64'(active_cycles), 64'd0);
    @(posedge clk); #1;

    run_tile(3, -1, 0, -1, 1'b1, -1);
    basic_literals();

    run_tile(3, 2, 0, -1, 1'b1, -1);
    chk("lit_gap_lw_count", 64'(lw_cnt), 64'd4);
    chk("lit_gap_done_lat", 64'(done_cyc - last_acc), 64'd7);

    run_tile(5, -1, 1, -1, 1'b1, -1);
    chk("lit_bub_stall",  64'(stall_cycles), 64'd4);
    chk("lit_bub_active", 64'(active_cycles), 64'd5);
    v = m0_hist[(first_acc + 1) % 64];
    chk("lit_bub_lane0_v", 64'(v[7:0]), 64'h01);
    v = m0_hist[(first_acc + 2) % 64];
    chk("lit_bub_lane0_0", 64'(v[7:0]), 64'h00);

    run_tile(0, -1, 0, -1, 1'b1, -1);
    chk("lit_nv0_done_cnt", 64'(done_cnt), 64'd1);
    chk("lit_nv0_done_lat", 64'(done_cyc - last_row_cyc), 64'd7);
    chk("lit_nv0_active",   64'(active_cycles), 64'd0);
    chk("lit_nv0_stall",    64'(stall_cycles), 64'd0);

    run_tile(4, -1, 0, 2, 1'b1, -1);
    chk("lit_zero_active", 64'(active_cycles), 64'd3);

    run_tile(20, -1, 1, -1, 1'b1, -1);
    chk("lit_sat_active", 64'(active_cycles), 64'd15);
    chk("lit_sat_stall",  64'(stall_cycles), 64'd15);

    run_tile(6, -1, 0, -1, 1'b1, 3);
    @(negedge clk);
    chk("lit_abort_phase", 64'(phase), 64'd0);
    chk("lit_abort_busy",  64'(busy), 64'd0);
    chk("lit_abort_m0",    64'(m0), 64'd0);
    chk("lit_abort_lw",    64'(load_weight), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("lit_abort_no_done", 64'(done_cnt), 64'd0);

    run_tile(3, -1, 0, -1, 1'b1, -1);
    basic_literals();

    for (int i = 0; i < 12; i++) begin
      nv = $urandom_range(0, 24);
      run_tile(nv, int'($urandom_range(0, 4)) - 1, 2, int'($urandom_range(0, 6)) - 1, 1'b0, -1);
      chk("rnd_done_cnt", 64'(done_cnt), 64'd1);
      chk("rnd_done_lat", 64'(done_cyc - ((nv == 0) ? last_row_cyc : last_acc)), 64'(DRAIN_LEN));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
